// File: rtl/hm01b0_pkg.sv
// Shared encodings for the HM01B0 sensor emulator: FSM states, pattern codes
// and the nibble-select helper used by the pixel generator.
package hm01b0_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_V_LEAD = 3'd1;
  localparam state_t ST_LINE   = 3'd2;
  localparam state_t ST_HBLANK = 3'd3;
  localparam state_t ST_V_TAIL = 3'd4;
  localparam state_t ST_GAP    = 3'd5;

  typedef logic [1:0] pattern_t;

  localparam pattern_t PAT_COUNTER = 2'd0;
  localparam pattern_t PAT_XMOD    = 2'd1;
  localparam pattern_t PAT_CONST   = 2'd2;
  localparam pattern_t PAT_CHECKER = 2'd3;

  localparam logic [7:0] CONST_PIXEL = 8'hA5;

  // Two-beat pixels go out MSB nibble first; one-beat pixels carry only the low nibble.
  function automatic logic [3:0] nibble_of(input logic [7:0] pix, input logic lo_half,
                                           input int nibbles);
    if (nibbles == 1 || lo_half) return pix[3:0];
    return pix[7:4];
  endfunction

endpackage

// File: rtl/hm01b0_pattern_gen.sv
// Combinational test-pattern pixel source with nibble selection.
module hm01b0_pattern_gen
  import hm01b0_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic [1:0] pattern_i,
  input  logic [7:0] x_i,
  input  logic       y_lsb_i,
  input  logic [7:0] count_i,
  input  logic       nib_i,
  output logic [3:0] nibble_o
);

  logic [7:0] pixel;

  // Select the 8-bit pixel value for the current frame's pattern.
  always_comb begin
    pixel = 8'h00;
    case (pattern_i)
      PAT_COUNTER: pixel = count_i;
      PAT_XMOD:    pixel = x_i;
      PAT_CONST:   pixel = CONST_PIXEL;
      PAT_CHECKER: pixel = (x_i[0] ^ y_lsb_i) ? 8'hFF : 8'h00;
      default:     pixel = 8'h00;
    endcase
  end

  assign nibble_o = nibble_of(pixel, nib_i, NIBBLES);

endmodule

// File: rtl/hm01b0_sensor_emulator.sv
// HM01B0 camera stand-in: pixclk = clock/2, frame FSM advancing on pixclk
// falling edges ("ticks") so vsync/hsync/pixdata are stable at every rise.
module hm01b0_sensor_emulator
  import hm01b0_pkg::*;
#(
  parameter int H_ACTIVE  = 324,
  parameter int V_ACTIVE  = 244,
  parameter int NIBBLES   = 2,
  parameter int H_BLANK   = 20,
  parameter int V_LEAD    = 8,
  parameter int V_TAIL    = 8,
  parameter int FRAME_GAP = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        pixclk,
  output logic        vsync,
  output logic        hsync,
  output logic [3:0]  pixdata,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  state_t      state_q, state_d;
  logic        pixclk_q;
  logic [15:0] beat_q, beat_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        nib_q, nib_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic        fstart_q, fstart_d;
  logic        fdone_q, fdone_d;
  logic [15:0] fcount_q, fcount_d;
  logic        launch;
  logic        tick;
  logic [3:0]  nibble;

  // The edge on which pixclk falls; every state change happens here.
  assign tick = pixclk_q;

  // Frame sequencer: counts beats in each phase and steps pixel coordinates.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    x_d      = x_q;
    y_d      = y_q;
    nib_d    = nib_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    fstart_d = 1'b0;
    fdone_d  = 1'b0;
    fcount_d = fcount_q;
    launch   = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: launch = enable;
        ST_V_LEAD: begin
          if (beat_q == 16'(V_LEAD - 1)) begin
            beat_d  = 16'd0;
            state_d = ST_LINE;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
        ST_LINE: begin
          if (nib_q == 1'(NIBBLES - 1)) begin
            nib_d = 1'b0;
            cnt_d = cnt_q + 8'd1;
            if (x_q == 16'(H_ACTIVE - 1)) begin
              x_d     = 16'd0;
              state_d = ST_HBLANK;
            end else begin
              x_d = x_q + 16'd1;
            end
          end else begin
            nib_d = nib_q + 1'b1;
          end
        end
        ST_HBLANK: begin
          if (beat_q == 16'(H_BLANK - 1)) begin
            beat_d = 16'd0;
            if (y_q == 16'(V_ACTIVE - 1)) begin
              state_d = ST_V_TAIL;
            end else begin
              y_d     = y_q + 16'd1;
              state_d = ST_LINE;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
        ST_V_TAIL: begin
          if (beat_q == 16'(V_TAIL - 1)) begin
            beat_d   = 16'd0;
            state_d  = ST_GAP;
            fdone_d  = 1'b1;
            fcount_d = fcount_q + 16'd1;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
        ST_GAP: begin
          if (beat_q == 16'(FRAME_GAP - 1)) begin
            beat_d = 16'd0;
            if (enable) launch = 1'b1;
            else        state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // New frame: latch the pattern and restart coordinates and the pixel counter.
      if (launch) begin
        state_d  = ST_V_LEAD;
        beat_d   = 16'd0;
        x_d      = 16'd0;
        y_d      = 16'd0;
        nib_d    = 1'b0;
        cnt_d    = 8'd0;
        pat_d    = pattern_sel;
        fstart_d = 1'b1;
      end
    end
  end

  // State, counters and pixclk; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pixclk_q <= 1'b0;
      beat_q   <= 16'd0;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      nib_q    <= 1'b0;
      cnt_q    <= 8'd0;
      pat_q    <= 2'd0;
      fstart_q <= 1'b0;
      fdone_q  <= 1'b0;
      fcount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      pixclk_q <= ~pixclk_q;
      beat_q   <= beat_d;
      x_q      <= x_d;
      y_q      <= y_d;
      nib_q    <= nib_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      fstart_q <= fstart_d;
      fdone_q  <= fdone_d;
      fcount_q <= fcount_d;
    end
  end

  hm01b0_pattern_gen #(
    .NIBBLES (NIBBLES)
  ) u_pattern (
    .pattern_i (pat_q),
    .x_i       (x_q[7:0]),
    .y_lsb_i   (y_q[0]),
    .count_i   (cnt_q),
    .nib_i     (nib_q),
    .nibble_o  (nibble)
  );

  // Sync/data outputs decode straight from registered state, so they only move on ticks.
  assign pixclk      = pixclk_q;
  assign vsync       = (state_q == ST_V_LEAD) || (state_q == ST_LINE) ||
                       (state_q == ST_HBLANK) || (state_q == ST_V_TAIL);
  assign hsync       = (state_q == ST_LINE);
  assign pixdata     = hsync ? nibble : 4'h0;
  assign frame_start = fstart_q;
  assign frame_done  = fdone_q;
  assign frame_count = fcount_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
